// File: rtl/head_gbus_collector_if.sv
// head_gbus_collector_if: per-core gbus write streams in, merged gbus write stream out (master drives cores/controls, slave is the collector)
interface head_gbus_collector_if #(
  parameter int CORE_NUM        = 4,
  parameter int GBUS_ADDR_WIDTH = 19,
  parameter int GBUS_DATA_WIDTH = 32
);
  logic [CORE_NUM*GBUS_ADDR_WIDTH-1:0] core_gbus_addr;
  logic [CORE_NUM-1:0]                 core_gbus_wen;
  logic [CORE_NUM*GBUS_DATA_WIDTH-1:0] core_gbus_wdata;
  logic                                gbus_hold;
  logic                                overflow_clear;
  logic [GBUS_ADDR_WIDTH-1:0]          out_gbus_addr;
  logic                                out_gbus_wen;
  logic [GBUS_DATA_WIDTH-1:0]          out_gbus_wdata;
  logic [CORE_NUM-1:0]                 overflow;
  logic                                idle;
  modport master (
    output core_gbus_addr, core_gbus_wen, core_gbus_wdata, gbus_hold, overflow_clear,
    input  out_gbus_addr, out_gbus_wen, out_gbus_wdata, overflow, idle
  );
  modport slave (
    input  core_gbus_addr, core_gbus_wen, core_gbus_wdata, gbus_hold, overflow_clear,
    output out_gbus_addr, out_gbus_wen, out_gbus_wdata, overflow, idle
  );
endinterface

// File: rtl/head_gbus_collector.sv
// head_gbus_collector: per-core write FIFOs, round-robin merge into one registered gbus write stream (ports: clk, rst async, gbus slave modport)
module head_gbus_collector #(
  parameter int CORE_NUM        = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int GBUS_ADDR_WIDTH = 19,
  parameter int GBUS_DATA_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  head_gbus_collector_if.slave  gbus
);
  localparam int W  = GBUS_ADDR_WIDTH + GBUS_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(CORE_NUM);
  logic [W-1:0]                 mem_q [CORE_NUM][FIFO_DEPTH];
  logic [PW-1:0]                wr_q [CORE_NUM];
  logic [PW-1:0]                rd_q [CORE_NUM];
  logic [PW:0]                  cnt_q [CORE_NUM];
  logic [PW:0]                  cnt_d [CORE_NUM];
  logic [IW-1:0]                rr_q, rr_d, grant;
  logic                         gnt_v, pop_any, idle_c;
  logic [CORE_NUM-1:0]          pop, push, drop, ovf_q, ovf_d;
  logic                         out_wen_q;
  logic [GBUS_ADDR_WIDTH-1:0]   out_addr_q;
  logic [GBUS_DATA_WIDTH-1:0]   out_data_q;
  // Search starts at rr_q so the most recently served core goes last next time.
  always_comb begin
    gnt_v = 1'b0;
    grant = '0;
    for (int k = 0; k < CORE_NUM; k++)
      if (!gnt_v && cnt_q[(int'(rr_q) + k) % CORE_NUM] != '0) begin
        gnt_v = 1'b1;
        grant = IW'((int'(rr_q) + k) % CORE_NUM);
      end
    pop_any = gnt_v && !gbus.gbus_hold;
    rr_d    = pop_any ? (grant == IW'(CORE_NUM - 1) ? '0 : grant + 1'b1) : rr_q;
    idle_c  = !out_wen_q;
    for (int i = 0; i < CORE_NUM; i++) begin
      pop[i]   = pop_any && grant == IW'(i);
      // A full FIFO still takes the write when it is popped on the same edge.
      push[i]  = gbus.core_gbus_wen[i] && (cnt_q[i] != (PW+1)'(FIFO_DEPTH) || pop[i]);
      drop[i]  = gbus.core_gbus_wen[i] && !push[i];
      cnt_d[i] = cnt_q[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      if (cnt_q[i] != '0) idle_c = 1'b0;
    end
    ovf_d = (ovf_q & ~{CORE_NUM{gbus.overflow_clear}}) | drop;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      ovf_q      <= '0;
      out_wen_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      for (int i = 0; i < CORE_NUM; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      ovf_q     <= ovf_d;
      out_wen_q <= pop_any;
      {out_addr_q, out_data_q} <= pop_any ? mem_q[grant][rd_q[grant]] : '0;
      for (int i = 0; i < CORE_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
        if (pop[i]) rd_q[i] <= rd_q[i] + 1'b1;
      end
    end
  end
  // Storage is not reset; occupancy counters alone define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CORE_NUM; i++)
      if (push[i])
        mem_q[i][wr_q[i]] <= {gbus.core_gbus_addr[i*GBUS_ADDR_WIDTH +: GBUS_ADDR_WIDTH],
                              gbus.core_gbus_wdata[i*GBUS_DATA_WIDTH +: GBUS_DATA_WIDTH]};
  end
  assign gbus.out_gbus_wen   = out_wen_q;
  assign gbus.out_gbus_addr  = out_addr_q;
  assign gbus.out_gbus_wdata = out_data_q;
  assign gbus.overflow       = ovf_q;
  assign gbus.idle           = idle_c;
endmodule

// File: tb/tb_head_gbus_collector.sv
// tb_head_gbus_collector: queue-based reference model with per-cycle compare, directed scenarios and random traffic
module tb_head_gbus_collector;
  localparam int N = 4;
  localparam int DEPTH = 4;
  localparam int A = 19;
  localparam int D = 32;
  typedef logic [A+D-1:0] ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  head_gbus_collector_if #(.CORE_NUM(N), .GBUS_ADDR_WIDTH(A), .GBUS_DATA_WIDTH(D)) gbus();
  head_gbus_collector #(.CORE_NUM(N), .FIFO_DEPTH(DEPTH), .GBUS_ADDR_WIDTH(A), .GBUS_DATA_WIDTH(D))
    dut (.clk(clk), .rst(rst), .gbus(gbus));
  int vectors = 0;
  int miscompares = 0;
  bit run_cmp = 1'b0;
  ent_t q[N][$];
  int rr = 0;
  logic exp_wen = 1'b0;
  logic [A-1:0] exp_addr = '0;
  logic [D-1:0] exp_data = '0;
  logic [N-1:0] exp_ovf = '0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: pop chosen from pre-edge queue contents, then clears, then pushes (set beats clear).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) q[i].delete();
      rr = 0;
      exp_wen = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_ovf = '0;
    end else begin
      int g;
      ent_t v;
      g = -1;
      if (!gbus.gbus_hold)
        for (int k = 0; k < N; k++)
          if (g < 0 && q[(rr + k) % N].size() > 0) g = (rr + k) % N;
      if (g >= 0) begin
        v = q[g].pop_front();
        {exp_addr, exp_data} = v;
        exp_wen = 1'b1;
        rr = (g + 1) % N;
      end else begin
        exp_wen = 1'b0;
        exp_addr = '0;
        exp_data = '0;
      end
      if (gbus.overflow_clear) exp_ovf = '0;
      for (int i = 0; i < N; i++)
        if (gbus.core_gbus_wen[i]) begin
          if (q[i].size() < DEPTH)
            q[i].push_back({gbus.core_gbus_addr[i*A +: A], gbus.core_gbus_wdata[i*D +: D]});
          else
            exp_ovf[i] = 1'b1;
        end
    end
  end
  always @(negedge clk) begin
    if (run_cmp) begin
      logic exp_idle;
      exp_idle = !exp_wen;
      for (int i = 0; i < N; i++) if (q[i].size() != 0) exp_idle = 1'b0;
      chk("model_wen", 64'(gbus.out_gbus_wen), 64'(exp_wen));
      chk("model_addr", 64'(gbus.out_gbus_addr), 64'(exp_addr));
      chk("model_data", 64'(gbus.out_gbus_wdata), 64'(exp_data));
      chk("model_ovf", 64'(gbus.overflow), 64'(exp_ovf));
      chk("model_idle", 64'(gbus.idle), 64'(exp_idle));
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic clr_in();
    gbus.core_gbus_wen = '0;
    gbus.overflow_clear = 1'b0;
  endtask
  task automatic put(int i, logic [A-1:0] a, logic [D-1:0] d);
    gbus.core_gbus_wen[i] = 1'b1;
    gbus.core_gbus_addr[i*A +: A] = a;
    gbus.core_gbus_wdata[i*D +: D] = d;
  endtask
  task automatic do_reset();
    clr_in();
    gbus.gbus_hold = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask
  initial begin
    gbus.core_gbus_addr = '0;
    gbus.core_gbus_wdata = '0;
    gbus.core_gbus_wen = '0;
    gbus.gbus_hold = 1'b0;
    gbus.overflow_clear = 1'b0;
    #2;
    do_reset();
    run_cmp = 1'b1;
    chk("rst_wen", 64'(gbus.out_gbus_wen), 64'd0);
    chk("rst_ovf", 64'(gbus.overflow), 64'd0);
    chk("rst_idle", 64'(gbus.idle), 64'd1);
    // Single write: two-edge latency, one output cycle.
    put(2, 19'h04010, 32'hDEADBEEF);
    tick();
    clr_in();
    chk("t1_wen_early", 64'(gbus.out_gbus_wen), 64'd0);
    tick();
    chk("t1_wen", 64'(gbus.out_gbus_wen), 64'd1);
    chk("t1_addr", 64'(gbus.out_gbus_addr), 64'h04010);
    chk("t1_data", 64'(gbus.out_gbus_wdata), 64'hDEADBEEF);
    tick();
    chk("t1_wen_after", 64'(gbus.out_gbus_wen), 64'd0);
    chk("t1_idle", 64'(gbus.idle), 64'd1);
    // All cores at once from rr=0.
    do_reset();
    for (int i = 0; i < N; i++) put(i, 19'(i), 32'h100 + 32'(i));
    tick();
    clr_in();
    for (int i = 0; i < N; i++) begin
      tick();
      chk("t2_data", 64'(gbus.out_gbus_wdata), 64'h100 + 64'(i));
    end
    put(1, 19'h1, 32'h201);
    put(0, 19'h0, 32'h200);
    tick();
    clr_in();
    tick();
    chk("t2_rr_wrap", 64'(gbus.out_gbus_wdata), 64'h200);
    tick();
    chk("t2_rr_next", 64'(gbus.out_gbus_wdata), 64'h201);
    // Hold fill with overflow, then drain.
    do_reset();
    gbus.gbus_hold = 1'b1;
    for (int d = 1; d <= 5; d++) begin
      put(1, 19'(d), 32'(d));
      tick();
    end
    clr_in();
    chk("t4_ovf", 64'(gbus.overflow), 64'b0010);
    gbus.gbus_hold = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk("t4_wen", 64'(gbus.out_gbus_wen), 64'd1);
      chk("t4_data", 64'(gbus.out_gbus_wdata), 64'(d));
    end
    tick();
    chk("t4_done", 64'(gbus.out_gbus_wen), 64'd0);
    // Full FIFO: push with pop accepted; drop with clear keeps the flag.
    do_reset();
    gbus.gbus_hold = 1'b1;
    for (int d = 0; d < 4; d++) begin
      put(0, 19'h50, 32'h50 + 32'(d));
      tick();
    end
    gbus.gbus_hold = 1'b0;
    put(0, 19'h50, 32'h54);
    tick();
    clr_in();
    chk("t5_no_ovf", 64'(gbus.overflow), 64'd0);
    chk("t5_pop", 64'(gbus.out_gbus_wdata), 64'h50);
    gbus.gbus_hold = 1'b1;
    put(0, 19'h50, 32'h55);
    gbus.overflow_clear = 1'b1;
    tick();
    clr_in();
    chk("t5_set_wins", 64'(gbus.overflow), 64'd1);
    gbus.gbus_hold = 1'b0;
    for (int d = 1; d <= 4; d++) begin
      tick();
      chk("t5_drain", 64'(gbus.out_gbus_wdata), 64'h50 + 64'(d));
    end
    // Reset mid-drain.
    do_reset();
    gbus.gbus_hold = 1'b1;
    for (int d = 0; d < 5; d++) begin
      if (d < 3) put(0, 19'h60, 32'h60 + 32'(d));
      put(2, 19'h70, 32'h70 + 32'(d));
      tick();
      clr_in();
    end
    gbus.gbus_hold = 1'b0;
    tick();
    chk("t6_pre_wen", 64'(gbus.out_gbus_wen), 64'd1);
    chk("t6_pre_ovf", 64'(gbus.overflow), 64'b0100);
    rst = 1'b1;
    #1;
    chk("t6_rst_wen", 64'(gbus.out_gbus_wen), 64'd0);
    chk("t6_rst_ovf", 64'(gbus.overflow), 64'd0);
    chk("t6_rst_idle", 64'(gbus.idle), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_no_data", 64'(gbus.out_gbus_wen), 64'd0);
    end
    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      gbus.gbus_hold = ($urandom_range(0, 3) == 0);
      gbus.overflow_clear = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 35) put(i, 19'($urandom), $urandom);
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    clr_in();
    gbus.gbus_hold = 1'b0;
    for (int c = 0; c < 4 * DEPTH + 4; c++) tick();
    chk("final_idle", 64'(gbus.idle), 64'd1);
    run_cmp = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
